// File: rtl/debounce_event.sv
// debounce_event: multi-channel switch debouncer with edge, long-press and
// optional auto-repeat events.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   in[W]        raw asynchronous switch inputs
//   out[W]       debounced level per channel
//   rise[W]      1-cycle pulse, coincident with out going 0->1
//   fall[W]      1-cycle pulse, coincident with out going 1->0
//   long_press[W] 1-cycle pulse once per press, cycle after hold hits HOLD_TICKS
//   auto_repeat[W] 1-cycle auto-repeat pulse ("repeat" is a reserved word)
//
// Build option: define DEBOUNCE_EVENT_AUTOREPEAT_EN to enable auto-repeat;
// otherwise auto_repeat is tied low and no repeat counters exist.

module debounce_lane #(
  parameter int N            = 3,
  parameter int HOLD_TICKS   = 100,
  parameter int REPEAT_TICKS = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic sync,
  output logic out,
  output logic rise,
  output logic fall,
  output logic long_press,
  output logic auto_repeat
);
  localparam int HW = $clog2(HOLD_TICKS + 1);

  if (N < 2 || HOLD_TICKS < 1 || REPEAT_TICKS < 1) begin : g_param_err
    $error("debounce_lane: illegal parameter value");
  end

  logic [N-1:0]  sh;
  logic [HW-1:0] hold;
  logic          lp_done;   // long_press already fired for this press
  logic          out_n;
  logic          hold_full;

  assign hold_full = (hold == HW'(HOLD_TICKS));

  // Level only moves when the whole sample window agrees.
  always_comb begin
    out_n = out;
    if (sh == '0)     out_n = 1'b0;
    else if (&sh)     out_n = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh         <= '0;
      out        <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
      hold       <= '0;
      lp_done    <= 1'b0;
      long_press <= 1'b0;
    end else begin
      if (tick) sh <= {sh[N-2:0], sync};
      out  <= out_n;
      rise <= out_n & ~out;
      fall <= ~out_n & out;
      // Clearing on out_n (not out) wipes hold on the same edge fall asserts.
      if (!out_n)                         hold <= '0;
      else if (tick && out && !hold_full) hold <= hold + HW'(1);
      long_press <= out_n && hold_full && !lp_done;
      lp_done    <= out_n && (lp_done || hold_full);
    end
  end

`ifdef DEBOUNCE_EVENT_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  logic [RW-1:0] rep;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep         <= '0;
      auto_repeat <= 1'b0;
    end else begin
      auto_repeat <= 1'b0;
      if (!out_n) begin
        rep <= '0;
      end else if (tick && out && hold_full) begin
        if (rep == RW'(REPEAT_TICKS - 1)) begin
          rep         <= '0;
          auto_repeat <= 1'b1;
        end else begin
          rep <= rep + RW'(1);
        end
      end
    end
  end
`else
  assign auto_repeat = 1'b0;
`endif

endmodule

module debounce_event #(
  parameter int WIDTH        = 4,
  parameter int N            = 3,
  parameter int RATE         = 125000,
  parameter int HOLD_TICKS   = 100,
  parameter int REPEAT_TICKS = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] long_press,
  output logic [WIDTH-1:0] auto_repeat
);
  localparam int CW = (RATE > 1) ? $clog2(RATE) : 1;

  if (RATE < 1 || WIDTH < 1) begin : g_param_err
    $error("debounce_event: illegal parameter value");
  end

  logic [CW-1:0]    cnt;
  logic             tick;
  logic [WIDTH-1:0] s1, sync;

  // With RATE=1 cnt stays at 0 and tick is permanently high.
  assign tick = (cnt == CW'(RATE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= '0;
      sync <= '0;
    end else begin
      s1   <= in;
      sync <= s1;
    end
  end

  debounce_lane #(
    .N(N), .HOLD_TICKS(HOLD_TICKS), .REPEAT_TICKS(REPEAT_TICKS)
  ) u_lane [WIDTH-1:0] (
    .clk(clk), .rst(rst), .tick(tick), .sync(sync),
    .out(out), .rise(rise), .fall(fall),
    .long_press(long_press), .auto_repeat(auto_repeat)
  );

endmodule

// File: tb/tb_debounce_event.sv
// Scoreboard bench for debounce_event (WIDTH=2, N=3, RATE=4, HOLD=5, REPEAT=2).
// Stimulus pushes expected pulse events (tagged with the edge count since
// reset release) and level snapshots; the monitor pops and compares.
module tb_debounce_event;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] in  = 2'b00;
  logic [1:0] out, rise, fall, long_press, auto_repeat;

  debounce_event #(
    .WIDTH(2), .N(3), .RATE(4), .HOLD_TICKS(5), .REPEAT_TICKS(2)
  ) dut (
    .clk(clk), .rst(rst), .in(in), .out(out), .rise(rise), .fall(fall),
    .long_press(long_press), .auto_repeat(auto_repeat)
  );

  always #5 clk = ~clk;

  int ecount = 0;   // posedges since reset release; ticks land on multiples of 4
  int tcyc   = 0;   // free-running posedge count
  always @(posedge clk or posedge rst)
    if (rst) ecount <= 0; else ecount <= ecount + 1;
  always @(posedge clk) tcyc <= tcyc + 1;

  typedef struct {int cyc; logic [1:0] r, f, lp, rp, o;} ev_t;
  typedef struct {int tc; logic [1:0] o;} lv_t;
  ev_t evq[$];
  lv_t lvq[$];
  ev_t me;
  lv_t ml;
  bit  done = 1'b0;
  int  checks = 0, errors = 0;
  int  e0;

  task automatic exp_ev(input int cyc, input logic [1:0] r, f, lp, rp, o);
    ev_t e;
    e.cyc = cyc; e.r = r; e.f = f; e.lp = lp; e.rp = rp; e.o = o;
    evq.push_back(e);
  endtask

  task automatic exp_lv(input int tc, input logic [1:0] o);
    lv_t l;
    l.tc = tc; l.o = o;
    lvq.push_back(l);
  endtask

  task automatic wait_to(input int t);
    while (ecount < t) @(negedge clk);
  endtask

  task automatic align();
    @(negedge clk);
    while ((ecount % 4) != 0) @(negedge clk);
  endtask

  // Expected pattern for a held press on one channel, released at +40.
  task automatic long_press_seq(input logic [1:0] m);
    e0 = ecount;
    exp_ev(e0 + 13, m, 2'b00, 2'b00, 2'b00, m);
    exp_ev(e0 + 33, 2'b00, 2'b00, m, 2'b00, m);
`ifdef DEBOUNCE_EVENT_AUTOREPEAT_EN
    exp_ev(e0 + 40, 2'b00, 2'b00, 2'b00, m, m);
    exp_ev(e0 + 48, 2'b00, 2'b00, 2'b00, m, m);
`endif
    exp_ev(e0 + 53, 2'b00, m, 2'b00, 2'b00, 2'b00);
    in = m;
    wait_to(e0 + 40);
    in = 2'b00;
    wait_to(e0 + 64);
  endtask

  // Monitor: all comparisons happen here.
  always @(negedge clk) begin
    if (|{rise, fall, long_press, auto_repeat}) begin
      checks++;
      if (evq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d got r=%b f=%b lp=%b rp=%b o=%b",
                 ecount, rise, fall, long_press, auto_repeat, out);
      end else begin
        me = evq.pop_front();
        if (me.cyc != ecount || me.r !== rise || me.f !== fall ||
            me.lp !== long_press || me.rp !== auto_repeat || me.o !== out) begin
          errors++;
          $display("FAIL event got cyc=%0d r=%b f=%b lp=%b rp=%b o=%b required cyc=%0d r=%b f=%b lp=%b rp=%b o=%b",
                   ecount, rise, fall, long_press, auto_repeat, out,
                   me.cyc, me.r, me.f, me.lp, me.rp, me.o);
        end
      end
    end
    if (lvq.size() != 0 && lvq[0].tc == tcyc) begin
      ml = lvq.pop_front();
      checks++;
      if (out !== ml.o || {rise, fall, long_press, auto_repeat} !== 8'h00) begin
        errors++;
        $display("FAIL level tc=%0d got o=%b pulses=%b required o=%b pulses=0",
                 tcyc, out, {rise, fall, long_press, auto_repeat}, ml.o);
      end
    end
    if (done) begin
      checks++;
      if (evq.size() != 0 || lvq.size() != 0) begin
        errors++;
        $display("FAIL pending got ev=%0d lv=%0d required 0", evq.size(), lvq.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    exp_lv(tcyc + 1, 2'b00);           // reset state
    @(negedge clk);
    rst = 1'b0;

    // Short press on ch0 (4 ticks of hold): rise then fall, no long_press.
    align(); e0 = ecount;
    exp_ev(e0 + 13, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
    exp_ev(e0 + 29, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    in = 2'b01;
    wait_to(e0 + 16); in = 2'b00;
    wait_to(e0 + 40);

    // 4-cycle glitch on ch0: nothing may happen.
    align(); e0 = ecount;
    in = 2'b01;
    wait_to(e0 + 4); in = 2'b00;
    wait_to(e0 + 28);
    exp_lv(tcyc + 1, 2'b00);

    // Long press on ch1.
    align();
    long_press_seq(2'b10);

    // ch0 released after 3 ticks of hold, then re-pressed: hold restarts.
    align(); e0 = ecount;
    exp_ev(e0 + 13, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
    exp_ev(e0 + 25, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    in = 2'b01;
    wait_to(e0 + 12); in = 2'b00;
    wait_to(e0 + 28);
    long_press_seq(2'b01);

    // Both channels together.
    align(); e0 = ecount;
    exp_ev(e0 + 13, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11);
    exp_ev(e0 + 29, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
    in = 2'b11;
    wait_to(e0 + 16); in = 2'b00;
    wait_to(e0 + 40);

    // Reset mid-press (hold=3), input kept high through reset.
    align(); e0 = ecount;
    exp_ev(e0 + 13, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
    in = 2'b01;
    wait_to(e0 + 24);
    exp_lv(tcyc + 1, 2'b01);
    wait_to(e0 + 25);
    exp_lv(tcyc + 1, 2'b00);           // sampled before any further posedge
    @(posedge clk); #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_ev(13, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
    exp_ev(29, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
    wait_to(16); in = 2'b00;
    wait_to(40);

    done = 1'b1;
  end
endmodule
